// File: rtl/updown_sweep_ctrl.sv
// Sequencer for a WIDTH-bit up/down counter: paced sweeps between latched bounds,
// a fixed number of round trips per start, and a direct-load path while idle.
module updown_sweep_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE   = 4,
    parameter int NUM_SWEEPS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo_bound,
    input  logic [WIDTH-1:0] hi_bound,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_enable,
    output logic             cnt_set,
    output logic [WIDTH-1:0] cnt_set_value,
    output logic             cnt_up_down,
    output logic             busy,
    output logic             load_ack,
    output logic             sweep_done,
    output logic             bound_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] PRE_RELOAD = 8'(PRESCALE - 1);
    localparam logic [3:0] SWEEP_LAST = 4'(NUM_SWEEPS);

    state_t           state_q, state_d;
    logic [7:0]       presc_q, presc_d;
    logic [3:0]       sweep_q, sweep_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             en_q, en_d, set_q, set_d, ud_q, ud_d, busy_q, busy_d;
    logic             ack_q, ack_d, done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] sv_q, sv_d;
    logic             tick_s;

    assign tick_s = (presc_q == 8'd0);

    // Next-state logic; output registers are loaded with the value for the coming cycle
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sweep_d = sweep_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        en_d    = 1'b0;
        set_d   = 1'b0;
        sv_d    = '0;
        ud_d    = 1'b0;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    if (lo_bound < hi_bound) begin
                        lo_d    = lo_bound;
                        hi_d    = hi_bound;
                        sweep_d = 4'd0;
                        state_d = S_INIT;
                        set_d   = 1'b1;
                        sv_d    = lo_bound;
                        ud_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (load_req) begin
                    set_d = 1'b1;
                    sv_d  = load_value;
                    ack_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    presc_d = PRE_RELOAD;
                    state_d = S_UP;
                    ud_d    = 1'b1;
                end
            end
            S_UP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick_s) begin
                    presc_d = PRE_RELOAD;
                    if (count_in == hi_q) begin
                        state_d = S_DOWN;
                    end else begin
                        en_d = 1'b1;
                        ud_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q - 8'd1;
                    ud_d    = 1'b1;
                end
            end
            S_DOWN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick_s) begin
                    presc_d = PRE_RELOAD;
                    if (count_in == lo_q) begin
                        sweep_d = sweep_q + 4'd1;
                        if (sweep_d == SWEEP_LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_UP;
                            ud_d    = 1'b1;
                        end
                    end else begin
                        en_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            presc_q <= 8'd0;
            sweep_q <= 4'd0;
            lo_q    <= '0;
            hi_q    <= '0;
            en_q    <= 1'b0;
            set_q   <= 1'b0;
            sv_q    <= '0;
            ud_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sweep_q <= sweep_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            en_q    <= en_d;
            set_q   <= set_d;
            sv_q    <= sv_d;
            ud_q    <= ud_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cnt_enable    = en_q;
    assign cnt_set       = set_q;
    assign cnt_set_value = sv_q;
    assign cnt_up_down   = ud_q;
    assign busy          = busy_q;
    assign load_ack      = ack_q;
    assign sweep_done    = done_q;
    assign bound_err     = err_q;

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Sequencer that drives the control inputs of the 4-bit up/down counter (enable, set, set_value, up_down) so the counter sweeps back and forth between programmable bounds. Sweeps repeat for a fixed number of round trips, at a paced step rate.
The block also provides a handshaked direct-load path used when idle. It sits beside the counter: its outputs wire to the counter's control inputs, and the counter's count output feeds back to count_in.

Parameters:
WIDTH, 4, counter width; all bound/value/count ports are WIDTH bits.
PRESCALE, 4, clock cycles between counter steps; legal range 2..255.
NUM_SWEEPS, 2, number of up-then-down round trips per start; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  level-sampled request to begin a sweep sequence; acted on only in IDLE.
stop  in  1  abort; returns to IDLE from any state.
lo_bound  in  WIDTH  lower sweep bound, latched on accepted start.
hi_bound  in  WIDTH  upper sweep bound, latched on accepted start.
load_req  in  1  direct-load request; honoured only in IDLE.
load_value  in  WIDTH  value for direct load.
count_in  in  WIDTH  current counter value (feedback).
cnt_enable  out  1  to counter enable; one-cycle step pulse.
cnt_set  out  1  to counter set; one-cycle pulse.
cnt_set_value  out  WIDTH  to counter set_value; valid while cnt_set=1, else 0.
cnt_up_down  out  1  to counter up_down; 1=up, 0=down.
busy  out  1  high in any state other than IDLE.
load_ack  out  1  one-cycle pulse coincident with the load's cnt_set.
sweep_done  out  1  one-cycle pulse on normal completion.
bound_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. Reset forces state=IDLE, prescaler=0, sweep counter=0, and latched bounds=0. Reset mid-sweep aborts immediately, with no done pulse.
- States: IDLE, INIT, UP, DOWN, DONE.
- IDLE, priority stop > start > load_req:
  - stop=1: stay IDLE.
  - start=1 and lo_bound < hi_bound: latch both bounds, clear the sweep counter, go to INIT.
  - start=1 and lo_bound >= hi_bound: bound_err=1 for the next cycle, stay IDLE.
  - load_req=1 with no start: the next cycle has cnt_set=1, cnt_set_value=load_value, load_ack=1; stay IDLE.
- INIT: one cycle with cnt_set=1, cnt_set_value=lo latch. Load the prescaler with PRESCALE-1, then go to UP.
- UP/DOWN pacing:
  - The prescaler decrements each cycle.
  - A tick occurs when the prescaler is 0; on each tick it reloads PRESCALE-1.
  - Because PRESCALE>=2, count_in has settled from the previous step by each tick.
- UP tick:
  - count_in == hi latch: no step; go to DOWN, prescaler reloaded.
  - Otherwise: cnt_enable=1 with cnt_up_down=1 for one cycle.
- DOWN tick:
  - count_in == lo latch: increment the sweep counter. If the new value == NUM_SWEEPS, go to DONE; else go to UP. No step either way.
  - Otherwise: cnt_enable=1 with cnt_up_down=0 for one cycle.
- cnt_up_down reflects the current direction: 1 in INIT/UP, 0 in DOWN, 0 in IDLE/DONE.
- DONE: sweep_done=1 for one cycle, then IDLE.
- stop in INIT/UP/DOWN/DONE:
  - Next state is IDLE.
  - cnt_enable/cnt_set are 0 from the next cycle.
  - No sweep_done is issued; the counter keeps its value.
- start while busy is ignored. load_req while busy is ignored (no ack).
- Out-of-range count_in (outside [lo,hi], e.g. external set): the controller keeps stepping in the current direction until equality is seen. The counter's natural wrap-around is accepted; no error is flagged.
- Arithmetic: bounds are compared as unsigned WIDTH-bit values.
- The sweep counter is 4 bits and does not saturate within the legal range.

Test Plan:
1. PRESCALE=2, NUM_SWEEPS=1, lo=3, hi=6, start pulse:
   - One cnt_set with value 3.
   - Then exactly 3 up pulses (count 3→6), one idle tick, 3 down pulses (6→3).
   - Then a sweep_done pulse; busy falls the cycle after sweep_done.
2. start with lo=9, hi=9, then with lo=10, hi=2 -> bound_err pulses once each; busy stays 0; no cnt_set or cnt_enable.
3. IDLE, load_req=1, load_value=4'hC -> next cycle cnt_set=1, cnt_set_value=C, load_ack=1. The same request during a sweep gets no ack and no cnt_set.
4. NUM_SWEEPS=2, lo=0, hi=15 -> 15 up, 15 down, 15 up, 15 down pulses, then a single sweep_done. The counter never wraps.
5. stop asserted midway through the DOWN phase:
   - IDLE next cycle; no further cnt_enable.
   - sweep_done stays 0; count_in holds its value.
   - A subsequent start restarts from lo with a fresh INIT.
6. Async reset asserted mid-UP, between clock edges -> all outputs 0 immediately; IDLE after release. start and load_req together in IDLE -> start wins, no load_ack.
